// File: rtl/stream_pkt_pkg.sv
// Shared definitions for the packet framer: header layout, FSM state types
// and the header packing helper.
package stream_pkt_pkg;

  localparam int HDR_ID_LSB    = 56;
  localparam int HDR_SEQ_LSB   = 40;
  localparam int HDR_FLAGS_LSB = 32;
  localparam int HDR_LEN_LSB   = 0;

  localparam logic [7:0] DEFAULT_ID = 8'hDD;

  typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_HDR, R_DATA} rd_state_e;

  function automatic logic [63:0] pack_header(input logic [7:0]  id,
                                              input logic [15:0] seq,
                                              input logic [15:0] len);
    logic [63:0] h;
    h = '0;
    h[HDR_ID_LSB    +: 8]  = id;
    h[HDR_SEQ_LSB   +: 16] = seq;
    h[HDR_FLAGS_LSB +: 8]  = 8'h00;
    h[HDR_LEN_LSB   +: 16] = len;
    return h;
  endfunction

endpackage

// File: rtl/pkt_len_fifo.sv
// Small FIFO of committed packet lengths; the head entry is visible on dout
// without a read latency so the read side can peek it when building a header.
module pkt_len_fifo #(
  parameter int ADDR_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [15:0] din,
  input  logic        pop,
  output logic [15:0] dout,
  output logic        full,
  output logic        empty
);
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] PTR_ONE = 1;
  localparam logic [ADDR_BITS:0]   CNT_ONE = 1;

  logic [15:0]          mem [DEPTH];
  logic [ADDR_BITS-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [ADDR_BITS:0]   cnt_q, cnt_d;
  logic                 do_push, do_pop;

  assign full    = cnt_q[ADDR_BITS];
  assign empty   = (cnt_q == '0);
  assign dout    = mem[rp_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (do_push) wp_d = wp_q + PTR_ONE;
    if (do_pop)  rp_d = rp_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stream_pkt_framer.sv
// Store-and-forward packet framer: buffers whole packets, drops oversize or
// malformed ones, and emits a length-tagged header ahead of each payload.
module stream_pkt_framer
  import stream_pkt_pkg::*;
#(
  parameter int         DEPTH_BITS    = 12,
  parameter int         LEN_FIFO_BITS = 4,
  parameter int         MAX_PKT_LEN   = 2048,
  parameter logic [7:0] ID            = DEFAULT_ID
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [63:0] in_tdata,
  input  logic        in_tfirst,
  input  logic        in_tlast,
  input  logic        in_tvalid,
  output logic        in_tready,
  output logic [63:0] out_tdata,
  output logic        out_tlast,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic [31:0] pkt_count,
  output logic [31:0] drop_count,
  output logic [31:0] malformed_count
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  typedef logic [DEPTH_BITS-1:0] ptr_t;
  localparam ptr_t        PTR_ONE  = ptr_t'(1);
  localparam ptr_t        PTR_FULL = ptr_t'(DEPTH - 1);
  localparam logic [15:0] MAX_LEN  = 16'(MAX_PKT_LEN);

  logic [63:0] ram [DEPTH];
  logic [63:0] ram_rdata_q;
  logic        ram_we;
  ptr_t        ram_waddr;

  wr_state_e   w_state_q, w_state_d;
  ptr_t        wr_ptr_q, wr_ptr_d, wr_base_q, wr_base_d;
  logic [15:0] wlen_q, wlen_d;
  rd_state_e   r_state_q, r_state_d;
  ptr_t        rd_ptr_q, rd_ptr_d, fetch_ptr_q, fetch_ptr_d;
  logic [15:0] rem_q, rem_d, seq_q, seq_d;
  logic [63:0] out_tdata_q, out_tdata_d;
  logic        out_tlast_q, out_tlast_d, out_tvalid_q, out_tvalid_d;

  logic        len_push, len_pop, len_full, len_empty;
  logic [15:0] len_din, len_dout;
  logic        in_beat, start_full, pkt_full;
  logic        inc_pkt, inc_drop, inc_mal;

  pkt_len_fifo #(.ADDR_BITS(LEN_FIFO_BITS)) u_len_fifo (
    .clk(clk), .rst(rst), .push(len_push), .din(len_din), .pop(len_pop),
    .dout(len_dout), .full(len_full), .empty(len_empty)
  );

  assign in_tready  = ~len_full;
  assign in_beat    = in_tvalid & in_tready;
  // Outside W_PKT wr_ptr equals wr_base, so new packets always start at wr_base.
  assign start_full = ((wr_base_q - rd_ptr_q) == PTR_FULL);
  assign pkt_full   = ((wr_ptr_q - rd_ptr_q) == PTR_FULL);

  always_comb begin
    w_state_d = w_state_q;
    wr_ptr_d  = wr_ptr_q;
    wr_base_d = wr_base_q;
    wlen_d    = wlen_q;
    ram_we    = 1'b0;
    ram_waddr = wr_ptr_q;
    len_push  = 1'b0;
    len_din   = wlen_q;
    inc_drop  = 1'b0;
    inc_mal   = 1'b0;
    if (!ena) begin
      wr_ptr_d  = wr_base_q;
      w_state_d = W_IDLE;
    end else if (in_beat) begin
      if (in_tfirst) begin
        inc_mal  = (w_state_q == W_PKT);
        wr_ptr_d = wr_base_q;
        if (start_full) begin
          inc_drop  = 1'b1;
          w_state_d = in_tlast ? W_IDLE : W_DROP;
        end else begin
          ram_we    = 1'b1;
          ram_waddr = wr_base_q;
          wlen_d    = 16'd1;
          wr_ptr_d  = wr_base_q + PTR_ONE;
          w_state_d = W_PKT;
          if (in_tlast) begin
            len_push  = 1'b1;
            len_din   = 16'd1;
            wr_base_d = wr_base_q + PTR_ONE;
            w_state_d = W_IDLE;
          end
        end
      end else if (w_state_q == W_PKT) begin
        if (pkt_full || wlen_q == MAX_LEN) begin
          wr_ptr_d  = wr_base_q;
          inc_drop  = 1'b1;
          w_state_d = in_tlast ? W_IDLE : W_DROP;
        end else begin
          ram_we   = 1'b1;
          wlen_d   = wlen_q + 16'd1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          if (in_tlast) begin
            len_push  = 1'b1;
            len_din   = wlen_q + 16'd1;
            wr_base_d = wr_ptr_q + PTR_ONE;
            w_state_d = W_IDLE;
          end
        end
      end else if (w_state_q == W_DROP && in_tlast) begin
        w_state_d = W_IDLE;
      end
    end
  end

  // ram_rdata_q always holds ram[fetch_ptr_q]; each payload load advances the
  // fetch pointer so the next word is ready on the following cycle.
  always_comb begin
    r_state_d    = r_state_q;
    rd_ptr_d     = rd_ptr_q;
    fetch_ptr_d  = fetch_ptr_q;
    rem_d        = rem_q;
    seq_d        = seq_q;
    out_tdata_d  = out_tdata_q;
    out_tlast_d  = out_tlast_q;
    out_tvalid_d = out_tvalid_q;
    len_pop      = 1'b0;
    inc_pkt      = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (!len_empty) begin
          out_tdata_d  = pack_header(ID, seq_q, len_dout);
          out_tlast_d  = 1'b0;
          out_tvalid_d = 1'b1;
          rem_d        = len_dout;
          r_state_d    = R_HDR;
        end
      end
      R_HDR: begin
        if (out_tready) begin
          seq_d       = seq_q + 16'd1;
          len_pop     = 1'b1;
          out_tdata_d = ram_rdata_q;
          out_tlast_d = (rem_q == 16'd1);
          rem_d       = rem_q - 16'd1;
          fetch_ptr_d = fetch_ptr_q + PTR_ONE;
          r_state_d   = R_DATA;
        end
      end
      R_DATA: begin
        if (out_tready) begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          if (out_tlast_q) begin
            inc_pkt = 1'b1;
            if (!len_empty) begin
              out_tdata_d = pack_header(ID, seq_q, len_dout);
              out_tlast_d = 1'b0;
              rem_d       = len_dout;
              r_state_d   = R_HDR;
            end else begin
              out_tdata_d  = '0;
              out_tlast_d  = 1'b0;
              out_tvalid_d = 1'b0;
              r_state_d    = R_IDLE;
            end
          end else begin
            out_tdata_d = ram_rdata_q;
            out_tlast_d = (rem_q == 16'd1);
            rem_d       = rem_q - 16'd1;
            fetch_ptr_d = fetch_ptr_q + PTR_ONE;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= in_tdata;
    ram_rdata_q <= ram[fetch_ptr_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q    <= W_IDLE;
      wr_ptr_q     <= '0;
      wr_base_q    <= '0;
      wlen_q       <= '0;
      r_state_q    <= R_IDLE;
      rd_ptr_q     <= '0;
      fetch_ptr_q  <= '0;
      rem_q        <= '0;
      seq_q        <= '0;
      out_tdata_q  <= '0;
      out_tlast_q  <= 1'b0;
      out_tvalid_q <= 1'b0;
    end else begin
      w_state_q    <= w_state_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_base_q    <= wr_base_d;
      wlen_q       <= wlen_d;
      r_state_q    <= r_state_d;
      rd_ptr_q     <= rd_ptr_d;
      fetch_ptr_q  <= fetch_ptr_d;
      rem_q        <= rem_d;
      seq_q        <= seq_d;
      out_tdata_q  <= out_tdata_d;
      out_tlast_q  <= out_tlast_d;
      out_tvalid_q <= out_tvalid_d;
    end
  end

  assign out_tdata  = out_tdata_q;
  assign out_tlast  = out_tlast_q;
  assign out_tvalid = out_tvalid_q;

  logic [2:0]       cnt_inc;
  logic [2:0][31:0] cnt_val;
  assign cnt_inc = {inc_mal, inc_drop, inc_pkt};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [31:0] cnt_q, cnt_d;
    always_comb begin
      cnt_d = cnt_q;
      if (cnt_inc[gi] && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end
    assign cnt_val[gi] = cnt_q;
  end

  assign pkt_count       = cnt_val[0];
  assign drop_count      = cnt_val[1];
  assign malformed_count = cnt_val[2];

endmodule
